// File: rtl/slow_clock_ctrl.sv
// Run/stop/burst controller for a divided slow clock with a glitch-free ratio update path.
// State | meaning
// IDLE  | counter parked at 0, clkOut low, ratio updates applied immediately
// RUN   | free-running divide until a requested stop reaches a falling toggle
// BURST | divide for burstLen full clkOut periods, then return to IDLE
module slow_clock_ctrl #(
    parameter int              WIDTH  = 23,
    parameter logic [WIDTH-1:0] CYCLES = 23'd4999999,
    parameter int              BURSTW = 8
) (
    input  logic              clkIn,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              burst,
    input  logic [BURSTW-1:0] burstLen,
    input  logic              cfgReq,
    input  logic [WIDTH-1:0]  cfgCycles,
    output logic              cfgAck,
    output logic              clkOut,
    output logic              tick,
    output logic              busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    logic [1:0]        state;
    logic [1:0]        nextState;
    logic [WIDTH-1:0]  delay;
    logic [WIDTH-1:0]  ratio;
    logic [WIDTH-1:0]  shadow;
    logic [BURSTW-1:0] remain;
    logic              pend;
    logic              applied;
    logic              stopPend;

    logic termCount;
    logic fallEdge;
    logic applyNow;
    logic acceptNow;

    assign termCount = (state != IDLE) && (delay == ratio);
    assign fallEdge  = termCount && clkOut;
    // Ratio only moves while delay is 0 in IDLE or exactly at terminal count.
    assign applyNow  = pend && ((state == IDLE) || termCount);
    assign acceptNow = cfgReq && !cfgAck && !pend && !applied;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                end else if (burst && (burstLen != '0)) begin
                    nextState = BURST;
                end
            end
            RUN: begin
                if (fallEdge && stopPend) begin
                    nextState = IDLE;
                end
            end
            BURST: begin
                if (fallEdge && (stopPend || (remain == BURSTW'(1)))) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            delay    <= '0;
            ratio    <= CYCLES;
            shadow   <= CYCLES;
            clkOut   <= 1'b0;
            tick     <= 1'b0;
            remain   <= '0;
            stopPend <= 1'b0;
            pend     <= 1'b0;
            applied  <= 1'b0;
            cfgAck   <= 1'b0;
        end else begin
            state <= nextState;
            busy  <= (nextState != IDLE);
            tick  <= termCount;

            if (state == IDLE) begin
                delay  <= '0;
                clkOut <= 1'b0;
            end else if (termCount) begin
                delay  <= '0;
                clkOut <= ~clkOut;
            end else begin
                delay <= delay + WIDTH'(1);
            end

            if ((state == IDLE) && (nextState == BURST)) begin
                remain <= burstLen;
            end else if ((state == BURST) && fallEdge) begin
                remain <= remain - BURSTW'(1);
            end

            // A stop coinciding with a falling toggle is held for the next one.
            if (nextState == IDLE) begin
                stopPend <= 1'b0;
            end else if ((state != IDLE) && stop) begin
                stopPend <= 1'b1;
            end

            if (acceptNow) begin
                shadow <= cfgCycles;
                pend   <= 1'b1;
            end else if (applyNow) begin
                ratio <= shadow;
                pend  <= 1'b0;
            end

            applied <= applyNow;
            if (applied) begin
                cfgAck <= 1'b1;
            end else if (!cfgReq) begin
                cfgAck <= 1'b0;
            end
        end
    end

endmodule
